coin_acceptor: RTL

Front-end stage that turns the two raw coin-slot sensors into the one-cycle 2-bit coin codes consumed by `vending_machine` on its `in` input. It synchronizes and debounces each sensor, detects coin insertions, rejects ambiguous simultaneous hits, buffers pending coins in a small FIFO, and issues them one at a time with a guaranteed idle gap. Its `coin_out` drives `vending_machine.in` directly. Its `hold` input lets the system pause issue while the machine is busy.

---
 rtl/coin_pkg.sv | 14 +
 rtl/coin_debounce.sv | 63 ++++++
 rtl/coin_acceptor.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes and issue-FSM state type for the coin acceptor front end.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } issue_state_t;

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle pulse on each qualified rising edge of that level.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          prev;
    logic          started;
    logic          armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A sensor already high at reset release must be seen low before it can
    // produce an event, so edges are only armed once a low sample arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev    <= 1'b0;
            started <= 1'b0;
            armed   <= 1'b0;
        end else begin
            prev    <= level;
            started <= 1'b1;
            armed   <= armed | (started & ~sync1);
        end
    end

    assign rise = level & ~prev & armed;

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: debounces both sensors, queues coin events in a small
// FIFO and issues them to the vending machine as spaced one-cycle codes.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                coin5_raw,
    input  logic                                coin10_raw,
    input  logic                                hold,
    output logic [1:0]                          coin_out,
    output logic                                reject,
    output logic                                overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     pending
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic level5;
    logic level10;
    logic rise5;
    logic rise10;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk   (clk),
        .rst   (rst),
        .raw   (coin5_raw),
        .level (level5),
        .rise  (rise5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk   (clk),
        .rst   (rst),
        .raw   (coin10_raw),
        .level (level10),
        .rise  (rise10)
    );

    logic [1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    head;
    logic          full;
    logic          single;
    logic          both;
    logic [1:0]    code;
    logic          enq;
    logic          deq;
    logic          drop;

    issue_state_t  state;
    issue_state_t  state_next;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_next;
    logic [1:0]    coin_next;
    logic          can_issue;

    assign head   = mem[rd_ptr];
    assign full   = (count == CW'(FIFO_DEPTH));
    assign both   = rise5 & rise10;
    assign single = rise5 ^ rise10;
    assign code   = rise5 ? COIN_5 : COIN_10;
    assign enq    = single & (~full | deq);
    assign drop   = single & full & ~deq;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            reject   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            reject   <= both;
            overflow <= drop;
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pending   = count;
    assign can_issue = (count != '0) & ~hold;

    // The last GAP cycle may launch the next issue directly, so back-to-back
    // codes are exactly 1+GAP_CYCLES apart instead of paying an extra IDLE cycle.
    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        coin_next    = COIN_NONE;
        deq          = 1'b0;
        case (state)
            IDLE: begin
                if (can_issue) begin
                    state_next = ISSUE;
                    coin_next  = head;
                    deq        = 1'b1;
                end
            end
            ISSUE: begin
                state_next   = GAP;
                gap_cnt_next = '0;
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    if (can_issue) begin
                        state_next = ISSUE;
                        coin_next  = head;
                        deq        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt + GW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            coin_out <= COIN_NONE;
        end else begin
            state    <= state_next;
            gap_cnt  <= gap_cnt_next;
            coin_out <= coin_next;
        end
    end

endmodule
